// File: rtl/uart_mem_bridge.sv
// UART command-frame bridge to the byte-addressable data memory.
// Decodes W/B/R frames, performs the access in a single EXEC cycle and streams the response bytes back.
module uart_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    output logic [1:0]            mem_size,
    input  logic [31:0]           mem_rd,
    output logic                  busy,
    output logic                  err_overrun
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_EXEC, S_RESP} state_t;

    localparam logic [7:0]    OP_W  = 8'h57;
    localparam logic [7:0]    OP_B  = 8'h42;
    localparam logic [7:0]    OP_R  = 8'h52;
    localparam logic [7:0]    ACK   = 8'h06;
    localparam logic [7:0]    NAK   = 8'h15;
    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [32:0]   DEPTH_L = 33'(DEPTH);

    state_t        r_state, w_next;
    logic [7:0]    r_op;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_resp;
    logic [1:0]    r_cnt;
    logic [1:0]    r_left;
    logic [TW-1:0] r_timer;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;
    logic          r_err;

    logic          w_known;
    logic          w_last_data;
    logic          w_timeout;
    logic          w_accept;
    logic [32:0]   w_end;
    logic          w_oor;
    logic          w_we;

    assign w_known     = (rx_data == OP_W) || (rx_data == OP_B) || (rx_data == OP_R);
    assign w_last_data = (r_cnt == 2'd3) || (r_op == OP_B);
    assign w_timeout   = !rx_valid && (r_timer >= TMAX);
    assign w_accept    = r_tx_valid && tx_ready;
    // 33-bit sum so an address near 2^32 cannot wrap past the range check
    assign w_end       = {1'b0, r_addr} + ((r_op == OP_B) ? 33'd1 : 33'd4);
    assign w_oor       = w_end > DEPTH_L;

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: if (rx_valid) w_next = w_known ? S_ADDR : S_RESP;
            S_ADDR: begin
                if (rx_valid && r_cnt == 2'd3) w_next = (r_op == OP_R) ? S_EXEC : S_DATA;
                else if (w_timeout)            w_next = S_IDLE;
            end
            S_DATA: begin
                if (rx_valid && w_last_data) w_next = S_EXEC;
                else if (w_timeout)          w_next = S_IDLE;
            end
            S_EXEC: begin
                w_next = S_RESP;
                w_we   = (r_op != OP_R) && !w_oor;
            end
            S_RESP: if (w_accept && r_left == 2'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_resp     <= '0;
            r_cnt      <= '0;
            r_left     <= '0;
            r_timer    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_op    <= rx_data;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_data  <= '0;
                        if (!w_known) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= NAK;
                            r_left     <= '0;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= rx_data;
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_data[{r_cnt, 3'b000} +: 8] <= rx_data;
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_EXEC: begin
                    if (rx_valid) r_err <= 1'b1;
                    r_tx_valid <= 1'b1;
                    if (w_oor) begin
                        r_tx_data <= NAK;
                        r_left    <= '0;
                    end else if (r_op == OP_R) begin
                        r_tx_data <= mem_rd[7:0];
                        r_resp    <= {8'h00, mem_rd[31:8]};
                        r_left    <= 2'd3;
                    end else begin
                        r_tx_data <= ACK;
                        r_left    <= '0;
                    end
                end
                S_RESP: begin
                    if (rx_valid) r_err <= 1'b1;
                    if (w_accept) begin
                        if (r_left == 2'd0) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_data <= r_resp[7:0];
                            r_resp    <= {8'h00, r_resp[31:8]};
                            r_left    <= r_left - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign mem_we      = w_we;
    assign mem_addr    = ADDR_WIDTH'(r_addr);
    assign mem_wd      = r_data;
    assign mem_size    = (r_op == OP_W) ? 2'b10 : 2'b00;
    assign busy        = (r_state != S_IDLE);
    assign err_overrun = r_err;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: table of frames with expected writes/responses, plus
// hand sequences for timeout, overrun and mid-frame reset.
module tb_uart_mem_bridge;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [1:0]  mem_size;
    logic [31:0] mem_rd;
    logic        busy;
    logic        err_overrun;

    uart_mem_bridge #(.ADDR_WIDTH(32), .DEPTH(1024), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size),
        .mem_rd(mem_rd), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Behavioural 1 KiB memory: asynchronous read, write on the clock edge
    logic [7:0] mem [0:1023];
    logic [9:0] wa;
    assign wa     = mem_addr[9:0];
    assign mem_rd = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[wa] <= mem_wd[7:0];
            if (mem_size == 2'b10) begin
                mem[wa + 10'd1] <= mem_wd[15:8];
                mem[wa + 10'd2] <= mem_wd[23:16];
                mem[wa + 10'd3] <= mem_wd[31:24];
            end
        end
    end

    typedef struct {
        int unsigned nb;    // frame length in bytes
        logic [71:0] b;     // frame bytes, first byte in [7:0]
        int unsigned lat;   // negedges from last byte to first tx_valid
        logic        we;    // one write expected
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        int unsigned nr;    // response byte count
        logic [31:0] r;     // response bytes, first in [7:0]
        int unsigned bp;    // stall cycles per response byte
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          we_cnt = 0;
        logic [31:0] we_addr = '0;
        logic [31:0] we_wd = '0;
        logic [1:0]  we_size = '0;
        int          got = 0;
        int          first = 0;
        int          stall = 0;
        int          unstable = 0;
        int          gap = 0;
        logic [31:0] rbytes = '0;
        logic [7:0]  held = '0;
        for (int i = 0; i < int'(v.nb); i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            rx_valid = 1'b1;
            rx_data  = v.b[8*i +: 8];
        end
        for (int cyc = 1; cyc <= 200 && got < int'(v.nr); cyc++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            tx_ready = 1'b0;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_wd   = mem_wd;
                we_size = mem_size;
            end
            if (tx_valid) begin
                if (first == 0) first = cyc;
                if (stall < int'(v.bp)) begin
                    if (stall == 0) held = tx_data;
                    else if (tx_data !== held) unstable++;
                    stall++;
                end else begin
                    if (stall > 0 && tx_data !== held) unstable++;
                    rbytes[8*got +: 8] = tx_data;
                    got++;
                    tx_ready = 1'b1;
                    stall = 0;
                end
            end else if (got > 0) begin
                gap++;
            end
        end
        @(negedge clk);
        tx_ready = 1'b0;
        if (mem_we) we_cnt++;
        chk({tag, "_ntx"}, got, v.nr);
        chk({tag, "_txbytes"}, rbytes, v.r);
        chk({tag, "_latency"}, first, v.lat);
        chk({tag, "_we_count"}, we_cnt, {31'd0, v.we});
        if (v.we) begin
            chk({tag, "_addr"}, we_addr, v.addr);
            chk({tag, "_wd"}, we_wd, v.wd);
            chk({tag, "_size"}, {30'd0, we_size}, {30'd0, v.size});
        end
        if (v.nr > 1) chk({tag, "_valid_gap"}, gap, 0);
        if (v.bp > 0) chk({tag, "_held_stable"}, unstable, 0);
        chk({tag, "_tx_valid_end"}, {31'd0, tx_valid}, 0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wd"}, mem_wd, 0);
        chk({tag, "_mem_size"}, {30'd0, mem_size}, 0);
        chk({tag, "_err_overrun"}, {31'd0, err_overrun}, 0);
    endtask

    vec_t vecs[12];

    initial begin
        int          tx_seen;
        int          we_seen;
        logic        busy5;
        int          c;
        int          got;
        logic [31:0] rb;
        vec_t        v;

        vecs[0]  = '{9, 72'hDEADBEEF_00000010_57, 2, 1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1, 32'h06, 0};
        vecs[1]  = '{5, 72'h00000010_52,          2, 1'b0, 32'h0,   32'h0,        2'b00, 4, 32'hDEADBEEF, 0};
        vecs[2]  = '{6, 72'h55_00000011_42,       2, 1'b1, 32'h11,  32'h55,       2'b00, 1, 32'h06, 0};
        vecs[3]  = '{5, 72'h00000010_52,          2, 1'b0, 32'h0,   32'h0,        2'b00, 4, 32'hDEAD55EF, 5};
        vecs[4]  = '{1, 72'h33,                   1, 1'b0, 32'h0,   32'h0,        2'b00, 1, 32'h15, 0};
        vecs[5]  = '{9, 72'h04030201_000003FE_57, 2, 1'b0, 32'h0,   32'h0,        2'b00, 1, 32'h15, 0};
        vecs[6]  = '{9, 72'h44332211_000003FC_57, 2, 1'b1, 32'h3FC, 32'h44332211, 2'b10, 1, 32'h06, 0};
        vecs[7]  = '{6, 72'hAA_000003FF_42,       2, 1'b1, 32'h3FF, 32'hAA,       2'b00, 1, 32'h06, 0};
        vecs[8]  = '{5, 72'h000003FC_52,          2, 1'b0, 32'h0,   32'h0,        2'b00, 4, 32'hAA332211, 2};
        vecs[9]  = '{5, 72'h000003FD_52,          2, 1'b0, 32'h0,   32'h0,        2'b00, 1, 32'h15, 0};
        vecs[10] = '{6, 72'h77_00000400_42,       2, 1'b0, 32'h0,   32'h0,        2'b00, 1, 32'h15, 0};
        vecs[11] = '{5, 72'hFFFFFFFF_52,          2, 1'b0, 32'h0,   32'h0,        2'b00, 1, 32'h15, 0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: partial frame then silence
        send(8'h57);
        send(8'h10);
        @(negedge clk);
        rx_valid = 1'b0;
        tx_seen = 0;
        we_seen = 0;
        busy5 = 1'b0;
        for (int k = 0; k < TO + 20; k++) begin
            @(negedge clk);
            if (tx_valid) tx_seen++;
            if (mem_we) we_seen++;
            if (k == 5) busy5 = busy;
        end
        chk("timeout_busy_during", {31'd0, busy5}, 1);
        chk("timeout_busy_after", {31'd0, busy}, 0);
        chk("timeout_no_tx", tx_seen, 0);
        chk("timeout_no_we", we_seen, 0);

        // Read after timeout, with a stray byte during the response
        chk("overrun_clear_before", {31'd0, err_overrun}, 0);
        send(8'h52); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        c = 0;
        while (!tx_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("overrun_tx_valid", {31'd0, tx_valid}, 1);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("overrun_flag", {31'd0, err_overrun}, 1);
        chk("overrun_first_byte", {24'd0, tx_data}, 32'hEF);
        got = 0;
        rb = '0;
        c = 0;
        while (got < 4 && c < 20) begin
            if (tx_valid) begin
                rb[8*got +: 8] = tx_data;
                got++;
                tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        tx_ready = 1'b0;
        chk("overrun_read_bytes", rb, 32'hDEAD55EF);
        chk("overrun_tx_valid_end", {31'd0, tx_valid}, 0);
        chk("overrun_sticky", {31'd0, err_overrun}, 1);

        // Reset after three bytes of a W frame
        send(8'h57); send(8'h20); send(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("midreset");
        v = '{9, 72'hCAFEF00D_00000020_57, 2, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1, 32'h06, 0};
        run_vec(v, "post_reset_write");
        v = '{5, 72'h00000020_52, 2, 1'b0, 32'h0, 32'h0, 2'b00, 4, 32'hCAFEF00D, 1};
        run_vec(v, "post_reset_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Initiator/master for the byte-addressable data memory: drives its write-enable, address, write-data and write-size inputs, and samples its asynchronous read-data output.
- Accepts command frames as a byte stream from the UART receiver and returns response bytes to the UART transmitter.
- Used for program/data loading and debug peek/poke while the core is held via busy.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DEPTH, 1024, memory size in bytes; used for range check.
- TIMEOUT_CYCLES, 100000, maximum idle gap between bytes inside one frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
- tx_data  output  8  response byte.
- tx_valid  output  1  response byte available.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory byte address.
- mem_wd  output  32  memory write data, byte 0 in [7:0].
- mem_size  output  2  write size: 00=1B, 10=4B (01/11 never driven).
- mem_rd  input  32  memory read data, combinational from mem_addr.
- busy  output  1  high whenever state is not IDLE.
- err_overrun  output  1  sticky: a byte arrived while in EXEC/RESP.

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE; tx_valid=0, tx_data=0, mem_we=0, mem_addr=0, mem_wd=0, mem_size=00, busy=0, err_overrun=0; all counters cleared. Reset mid-frame or mid-response aborts with no write and no further tx bytes.
- Frames, multi-byte fields little-endian:
  - 0x57 'W' + addr[4] + data[4]: 4B write, respond 0x06.
  - 0x42 'B' + addr[4] + data[1]: 1B write, respond 0x06.
  - 0x52 'R' + addr[4]: respond with 4 bytes mem_rd[7:0], [15:8], [23:16], [31:24].
- Unknown opcode in IDLE: go directly to RESP and send 0x15 (NAK); no memory access.
- States:
  - IDLE: wait for rx_valid; latch opcode.
  - ADDR: collect 4 bytes.
  - DATA: collect 4 or 1 bytes ('R' skips DATA).
  - EXEC: one cycle.
  - RESP: send the response bytes.
  - After the last response byte is accepted, return to IDLE.
- mem_addr is driven from the address register, updated as bytes arrive. mem_wd and mem_size are driven from the data register and opcode.
- EXEC (cycle after the last frame byte):
  - Range check: addr + nbytes > DEPTH gives NAK; no write, no read.
  - Otherwise, 'W'/'B': mem_we=1 for exactly this cycle, with mem_size=10 or 00 respectively.
  - Otherwise, 'R': mem_we=0; mem_rd is captured into the response shift register this cycle.
- Latency: last frame byte at cycle N -> EXEC at N+1 -> tx_valid=1 at N+2.
- tx handshake:
  - tx_data is stable and tx_valid is held until a cycle with tx_valid&tx_ready.
  - The next byte is presented on the following cycle; tx_valid stays high between bytes of a multi-byte response.
  - tx_ready is ignored while tx_valid=0.
- Timeout: in ADDR/DATA, a cycle counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES without a byte, return to IDLE silently, with no write and no response. The counter is inactive in IDLE/EXEC/RESP.
- rx_valid in EXEC or RESP: the byte is dropped and err_overrun is set to 1. err_overrun clears only on reset.
- mem_we is never high outside EXEC. busy=0 only in IDLE.

Test Plan:
- Write word: bytes 57 10 00 00 00 EF BE AD DE.
  - EXEC: exactly one cycle mem_we=1, mem_addr=0x10, mem_wd=0xDEADBEEF, mem_size=10.
  - Then tx 0x06.
- Read back, then byte write:
  - 52 10 00 00 00 -> tx EF, BE, AD, DE in order.
  - 42 11 00 00 00 55 -> 1B write at 0x11, mem_size=00.
  - Re-read 0x10 -> EF, 55, AD, DE.
- Backpressure: tx_ready low 5 cycles per byte during the read response -> each byte is held stable, none lost or duplicated, tx_valid stays high throughout.
- Errors:
  - Opcode 0x33 -> tx 0x15, no mem_we.
  - 57 FE 03 00 00 + 4 data (addr 0x3FE, DEPTH 1024) -> tx 0x15, no mem_we.
- Timeout/overrun:
  - 57 10 then TIMEOUT_CYCLES idle -> back to IDLE, busy=0, no tx.
  - A following 52 frame works normally.
  - A byte sent during RESP -> err_overrun=1.
- Reset mid-frame: assert reset after 3 bytes of a 'W' frame -> all outputs at reset values next cycle, no write; the next full frame succeeds.
